fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_queue.sv | 37 +++
 rtl/fetch_unit.sv | 46 ++++
 tb/tb_fetch_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch queue entry type
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetch entries (push/pop/flush in; full/empty/head out), flush beats push and pop
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head  = mem[rp];
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push && !flush && !reset) mem[wp] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/imem_addr owner, captures imem_rd with its PC into fetch_queue, presents head via instr_valid/instr_ready, redirect flushes and reloads PC
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);
  logic [WIDTH-1:0] pc;
  logic push, pop, full, empty;
  fetch_entry_t head, din;
  assign imem_addr   = pc;
  assign instr_valid = !empty;
  assign pop         = instr_valid && instr_ready;
  assign push        = !redirect_valid && (!full || pop);
  assign din         = '{pc: pc, instr: imem_rd};
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (din),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[WIDTH-1:2], 2'b00};
    else if (push) pc <= pc + WIDTH'(INSTR_BYTES);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, redirect_valid = 0, instr_ready = 0, instr_valid;
  logic [31:0] imem_addr, imem_rd, redirect_pc = 0, instr, instr_pc;
  int compared = 0, mismatched = 0;
  logic [31:0] q[$];
  logic [31:0] mpc = 0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign imem_rd = rom(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
    logic [31:0] tmp;
    reset = r; redirect_valid = rv; redirect_pc = rp; instr_ready = rd;
    if (r) begin
      q.delete(); mpc = 0;
    end else if (rv) begin
      q.delete(); mpc = {rp[31:2], 2'b00};
    end else begin
      if (q.size() > 0 && rd) tmp = q.pop_front();
      if (q.size() < DEPTH) begin
        q.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("m_valid", 32'(instr_valid), 32'(q.size() > 0));
    chk("m_pc", instr_pc, q.size() > 0 ? q[0] : 32'h0);
    chk("m_instr", instr, q.size() > 0 ? rom(q[0]) : 32'h0);
    chk("m_addr", imem_addr, mpc);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 0);
    step(0, 0, 0, 1);
    chk("seq0_pc", instr_pc, 32'h0);
    chk("seq0_in", instr, 32'hA000_0000);
    step(0, 0, 0, 1);
    chk("seq1_pc", instr_pc, 32'h4);
    chk("seq1_in", instr, 32'hA000_0001);
    step(0, 0, 0, 1);
    chk("seq2_pc", instr_pc, 32'h8);
    chk("seq2_in", instr, 32'hA000_0002);

    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", instr_pc, 32'h0);
    chk("stall_in", instr, 32'hA000_0000);
    step(0, 0, 0, 1);
    chk("rel0_pc", instr_pc, 32'h4);
    step(0, 0, 0, 1);
    chk("rel1_pc", instr_pc, 32'h8);
    step(0, 0, 0, 1);
    chk("rel2_pc", instr_pc, 32'hC);
    chk("rel2_in", instr, 32'hA000_0003);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 1);
    chk("redir_valid", 32'(instr_valid), 0);
    chk("redir_addr", imem_addr, 32'h40);
    step(0, 0, 0, 1);
    chk("redir_pc", instr_pc, 32'h40);
    chk("redir_in", instr, 32'hA000_0010);
    step(0, 1, 32'h47, 1);
    chk("mis_addr", imem_addr, 32'h44);
    step(0, 0, 0, 1);
    chk("mis_pc", instr_pc, 32'h44);
    chk("mis_in", instr, 32'hA000_0011);

    step(0, 1, 32'h18, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_addr", imem_addr, 32'h20);
    step(1, 0, 0, 1);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_in", instr, 32'h0);
    step(0, 0, 0, 1);
    chk("post_rst_pc", instr_pc, 32'h0);
    chk("post_rst_in", instr, 32'hA000_0000);

    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 11) == 0),
           $urandom & 32'h3FF, 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
